// File: rtl/riscv_defines.sv
// Core-wide definitions shared across the pipeline. Only the privilege-level
// encoding is needed by the interrupt controller.
package riscv_defines;

  typedef enum logic [1:0] {
    PRIV_LVL_M = 2'b11,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_U = 2'b00
  } PrivLvl_t;

endpackage

// File: rtl/riscv_int_controller_nch_pkg.sv
// Types local to the multi-line interrupt controller.
package riscv_int_controller_nch_pkg;

  // Request handshake with the core controller.
  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    IRQ_PENDING = 2'b01,
    IRQ_DONE    = 2'b10
  } int_ctrl_state_e;

endpackage

// File: rtl/riscv_irq_prio_sel.sv
// Fixed-priority selector: picks the highest set index of req_i.
//   req_i   : candidate vector
//   valid_o : at least one bit of req_i is set
//   id_o    : index of the highest set bit (0 when none)
module riscv_irq_prio_sel #(
  parameter int unsigned NUM_IRQ = 32,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Ascending scan: the last hit, i.e. the highest index, wins.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (req_i[i]) begin
        id_o = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/riscv_int_controller_nch.sv
// Multi-line interrupt controller. Latches rising-edge events into pending
// bits, selects the highest-index pending and enabled line and presents it to
// the core controller through an IDLE/PENDING/DONE handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   setback_i           : synchronous clear of FSM, latched id/sec, pending bits
//   irq_i               : interrupt lines
//   irq_sec_i           : per-line secure bit
//   irq_mask_i          : per-line enable
//   irq_edge_i          : per-line mode, 1 = rising edge, 0 = level
//   m_IE_i, u_IE_i      : global M/U-mode interrupt enables
//   current_priv_lvl_i  : current privilege level
//   irq_req_ctrl_o      : request to core controller
//   irq_sec_ctrl_o      : secure bit of the latched request
//   irq_id_ctrl_o       : id of the latched request
//   ctrl_ack_i          : controller accepted the request
//   ctrl_kill_i         : controller dropped the request
//   irq_ack_o           : one-cycle acknowledge to the source
//   irq_ack_id_o        : id being acknowledged
module riscv_int_controller_nch
  import riscv_defines::*;
  import riscv_int_controller_nch_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned ID_W        = $clog2(NUM_IRQ),
  parameter int unsigned PULP_SECURE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               setback_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_sec_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic [NUM_IRQ-1:0] irq_edge_i,
  input  logic               m_IE_i,
  input  logic               u_IE_i,
  input  PrivLvl_t           current_priv_lvl_i,
  output logic               irq_req_ctrl_o,
  output logic               irq_sec_ctrl_o,
  output logic [ID_W-1:0]    irq_id_ctrl_o,
  input  logic               ctrl_ack_i,
  input  logic               ctrl_kill_i,
  output logic               irq_ack_o,
  output logic [ID_W-1:0]    irq_ack_id_o
);

  int_ctrl_state_e    state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               sec_q, sec_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] irq_prev_q;

  logic [NUM_IRQ-1:0] eff;
  logic [NUM_IRQ-1:0] clr;
  logic               sel_valid;
  logic [ID_W-1:0]    sel_id;
  logic               sel_sec;
  logic               irq_en;

  // Edge lines report their latched event, level lines the live input.
  assign eff = ((irq_edge_i & pend_q) | (~irq_edge_i & irq_i)) & irq_mask_i;

  riscv_irq_prio_sel #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_sel (
    .req_i   (eff),
    .valid_o (sel_valid),
    .id_o    (sel_id)
  );

  assign sel_sec = irq_sec_i[sel_id];

  always_comb begin
    if (PULP_SECURE != 0) begin
      // Secure lines may interrupt user mode even with u_IE cleared.
      irq_en = ((u_IE_i | sel_sec) & (current_priv_lvl_i == PRIV_LVL_U)) |
               (m_IE_i & (current_priv_lvl_i == PRIV_LVL_M));
    end else begin
      irq_en = m_IE_i;
    end
  end

  // Pending bits: clear the serviced line during DONE; a new edge in the same
  // cycle overrides the clear so the event is not lost.
  always_comb begin
    clr = '0;
    if (state_q == IRQ_DONE) begin
      clr[id_q] = 1'b1;
    end
    pend_d = ((pend_q & ~clr) | (irq_i & ~irq_prev_q)) & irq_edge_i;
    if (setback_i) begin
      pend_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    sec_d     = sec_q;
    irq_ack_o = 1'b0;
    irq_ack_id_o = '0;

    unique case (state_q)
      IDLE: begin
        if (sel_valid && irq_en) begin
          id_d    = sel_id;
          sec_d   = sel_sec;
          state_d = IRQ_PENDING;
        end
      end
      IRQ_PENDING: begin
        // id/sec stay frozen here even if a higher line shows up.
        if (ctrl_ack_i) begin
          state_d = IRQ_DONE;
        end else if (ctrl_kill_i) begin
          state_d = IDLE;
        end
      end
      IRQ_DONE: begin
        irq_ack_o    = 1'b1;
        irq_ack_id_o = id_q;
        sec_d        = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (setback_i) begin
      state_d = IDLE;
      id_d    = '0;
      sec_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      sec_q      <= 1'b0;
      pend_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      sec_q      <= sec_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_i;
    end
  end

  assign irq_req_ctrl_o = (state_q == IRQ_PENDING);
  assign irq_sec_ctrl_o = sec_q;
  assign irq_id_ctrl_o  = id_q;

endmodule

// File: tb/tb_riscv_int_controller_nch.sv
// Directed bench for riscv_int_controller_nch. Two instances share stimulus:
// dut_n (PULP_SECURE=0) and dut_s (PULP_SECURE=1). Expected output tuples are
// queued when stimulus is driven and compared one cycle later.
module tb_riscv_int_controller_nch;
  import riscv_defines::*;

  localparam int unsigned N  = 32;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          setback;
  logic [N-1:0]  irq, irq_sec, irq_mask, irq_edge;
  logic          m_ie, u_ie;
  PrivLvl_t      priv;
  logic          ack, kill;

  logic          req_n, sec_n, iack_n, req_s, sec_s, iack_s;
  logic [IW-1:0] id_n, aid_n, id_s, aid_s;
  logic [12:0]   obs_n, obs_s;

  always #5 clk = ~clk;

  riscv_int_controller_nch #(.NUM_IRQ(N), .ID_W(IW), .PULP_SECURE(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .setback_i(setback), .irq_i(irq), .irq_sec_i(irq_sec),
    .irq_mask_i(irq_mask), .irq_edge_i(irq_edge), .m_IE_i(m_ie), .u_IE_i(u_ie),
    .current_priv_lvl_i(priv), .irq_req_ctrl_o(req_n), .irq_sec_ctrl_o(sec_n),
    .irq_id_ctrl_o(id_n), .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_ack_o(iack_n),
    .irq_ack_id_o(aid_n)
  );

  riscv_int_controller_nch #(.NUM_IRQ(N), .ID_W(IW), .PULP_SECURE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .setback_i(setback), .irq_i(irq), .irq_sec_i(irq_sec),
    .irq_mask_i(irq_mask), .irq_edge_i(irq_edge), .m_IE_i(m_ie), .u_IE_i(u_ie),
    .current_priv_lvl_i(priv), .irq_req_ctrl_o(req_s), .irq_sec_ctrl_o(sec_s),
    .irq_id_ctrl_o(id_s), .ctrl_ack_i(ack), .ctrl_kill_i(kill), .irq_ack_o(iack_s),
    .irq_ack_id_o(aid_s)
  );

  assign obs_n = {req_n, sec_n, id_n, iack_n, aid_n};
  assign obs_s = {req_s, sec_s, id_s, iack_s, aid_s};

  // which: 0 = both instances, 1 = dut_s only, 2 = dut_n only
  typedef struct {
    string       tag;
    int          which;
    logic [12:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic cmp(input string tag, input string inst, input logic [12:0] obs,
                     input logic [12:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s observed=%h expected=%h", tag, inst, obs, exp);
  endtask

  task automatic sb_push(input string tag, input int which, input logic req,
                         input logic sec, input logic [IW-1:0] id, input logic iack,
                         input logic [IW-1:0] aid);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.exp   = {req, sec, id, iack, aid};
    sb.push_back(e);
  endtask

  task automatic check_q();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.which != 2) cmp(e.tag, "s", obs_s, e.exp);
      if (e.which != 1) cmp(e.tag, "n", obs_n, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_q();
  endtask

  initial begin
    rst_n = 1'b0; setback = 1'b0; irq = '0; irq_sec = '0; irq_mask = '1; irq_edge = '0;
    m_ie = 1'b1; u_ie = 1'b0; priv = PRIV_LVL_M; ack = 1'b0; kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_push("reset", 0, 0, 0, 0, 0, 0);
    check_q();
    rst_n = 1'b1;

    // Level line 5: request next cycle, ack in cycle 3, DONE in cycle 4.
    irq = 32'h20;        sb_push("lvl_req", 0, 1, 0, 5, 0, 0);  tick();
    irq = '0;            sb_push("lvl_hold", 0, 1, 0, 5, 0, 0); tick();
    ack = 1'b1;          sb_push("lvl_done", 0, 0, 0, 5, 1, 5); tick();
    ack = 1'b0;          sb_push("lvl_idle", 0, 0, 0, 5, 0, 0); tick();

    // Priority among levels; request frozen while pending.
    irq = 32'h0000_8104; sb_push("prio_15", 0, 1, 0, 15, 0, 0);     tick();
    irq = 32'h0010_8104; sb_push("prio_frozen", 0, 1, 0, 15, 0, 0); tick();
    ack = 1'b1;          sb_push("prio_done15", 0, 0, 0, 15, 1, 15); tick();
    ack = 1'b0;          sb_push("prio_idle", 0, 0, 0, 15, 0, 0);   tick();
                         sb_push("prio_20", 0, 1, 0, 20, 0, 0);     tick();
    irq = '0; ack = 1'b1; sb_push("prio_done20", 0, 0, 0, 20, 1, 20); tick();
    ack = 1'b0;          sb_push("prio_idle2", 0, 0, 0, 20, 0, 0);  tick();

    // Edge line 3: masked pulse is remembered, fires on unmask.
    irq_edge = 32'h8; irq_mask = ~32'h8;
    irq = 32'h8;         sb_push("edge_masked", 0, 0, 0, 20, 0, 0);  tick();
    irq = '0;
    cmp("edge_pend_set", "s", 13'(dut_s.pend_q[3]), 13'd1);
                         sb_push("edge_masked2", 0, 0, 0, 20, 0, 0); tick();
    cmp("edge_pend_kept", "s", 13'(dut_s.pend_q[3]), 13'd1);
    irq_mask = '1;       sb_push("edge_req", 0, 1, 0, 3, 0, 0);      tick();
    ack = 1'b1;          sb_push("edge_done", 0, 0, 0, 3, 1, 3);     tick();
    ack = 1'b0;          sb_push("edge_idle", 0, 0, 0, 3, 0, 0);     tick();
    cmp("edge_pend_clr", "s", 13'(dut_s.pend_q[3]), 13'd0);
                         sb_push("edge_no_rereq", 0, 0, 0, 3, 0, 0); tick();
    // Pulse landing exactly in the DONE cycle must survive the clear.
    irq = 32'h8;         sb_push("edge2_idle", 0, 0, 0, 3, 0, 0);    tick();
    irq = '0;            sb_push("edge2_req", 0, 1, 0, 3, 0, 0);     tick();
    ack = 1'b1;          sb_push("edge2_done", 0, 0, 0, 3, 1, 3);    tick();
    ack = 1'b0; irq = 32'h8; sb_push("edge2_idle2", 0, 0, 0, 3, 0, 0); tick();
    irq = '0;
    cmp("edge_set_wins", "s", 13'(dut_s.pend_q[3]), 13'd1);
                         sb_push("edge_rereq", 0, 1, 0, 3, 0, 0);    tick();
    ack = 1'b1;          sb_push("edge3_done", 0, 0, 0, 3, 1, 3);    tick();
    ack = 1'b0;          sb_push("edge3_idle", 0, 0, 0, 3, 0, 0);    tick();
    irq_edge = '0;

    // Kill alone returns to IDLE and re-requests; ack beats kill.
    irq = 32'h200;       sb_push("kill_req", 0, 1, 0, 9, 0, 0);      tick();
    kill = 1'b1;         sb_push("kill_idle", 0, 0, 0, 9, 0, 0);     tick();
    kill = 1'b0;         sb_push("kill_rereq", 0, 1, 0, 9, 0, 0);    tick();
    ack = 1'b1; kill = 1'b1; sb_push("ackkill_done", 0, 0, 0, 9, 1, 9); tick();
    irq = '0; ack = 1'b0; kill = 1'b0; sb_push("ackkill_idle", 0, 0, 0, 9, 0, 0); tick();

    // Secure qualification in user mode.
    priv = PRIV_LVL_U; m_ie = 1'b0; u_ie = 1'b0;
    irq = 32'h80;        sb_push("u_nosec", 0, 0, 0, 9, 0, 0);       tick();
                         sb_push("u_nosec2", 0, 0, 0, 9, 0, 0);      tick();
    irq_sec = 32'h80;    sb_push("u_sec_req", 1, 1, 1, 7, 0, 0);
                         sb_push("u_sec_req", 2, 0, 0, 9, 0, 0);     tick();
    ack = 1'b1;          sb_push("u_sec_done", 1, 0, 1, 7, 1, 7);
                         sb_push("u_sec_done", 2, 0, 0, 9, 0, 0);    tick();
    irq = '0; ack = 1'b0; sb_push("u_sec_idle", 1, 0, 0, 7, 0, 0);
                         sb_push("u_sec_idle", 2, 0, 0, 9, 0, 0);    tick();
    priv = PRIV_LVL_M; irq = 32'h80;
                         sb_push("m_noie", 1, 0, 0, 7, 0, 0);
                         sb_push("m_noie", 2, 0, 0, 9, 0, 0);        tick();

    // Setback mid-request clears state and pending edge bits.
    m_ie = 1'b1; irq_sec = 32'h1000; irq_edge = 32'h18;
    irq = 32'h1018;      sb_push("sb_req", 0, 1, 1, 12, 0, 0);       tick();
    cmp("sb_pend_pre", "s", 13'(dut_s.pend_q[4:3]), 13'd3);
    irq = 32'h1000; setback = 1'b1; sb_push("sb_clear", 0, 0, 0, 0, 0, 0); tick();
    cmp("sb_pend_clr", "s", 13'(|dut_s.pend_q), 13'd0);
    setback = 1'b0; irq = '0; sb_push("sb_after", 0, 0, 0, 0, 0, 0); tick();
    irq_edge = '0; irq_sec = '0;

    // Asynchronous reset while in DONE.
    irq = 32'h40;        sb_push("rst_req", 0, 1, 0, 6, 0, 0);       tick();
    ack = 1'b1;          sb_push("rst_done", 0, 0, 0, 6, 1, 6);      tick();
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("rst_async", 0, 0, 0, 0, 0, 0);
    check_q();
    irq = '0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;        sb_push("rst_release", 0, 0, 0, 0, 0, 0);   tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_int_controller_nch.md
Name: riscv_int_controller_nch

Overview:
- Multi-line successor to the single-request interrupt controller.
- Accepts NUM_IRQ interrupt lines, each with its own mask bit, secure bit and level/edge mode. Latches edge events into pending bits and picks the highest-priority pending, unmasked line.
- Presents that line's request to the core controller with the same IDLE/PENDING/DONE handshake, and signals acknowledgement back to the source.

Parameters:
- NUM_IRQ, 32, number of interrupt lines (2..64)
- ID_W, $clog2(NUM_IRQ), width of interrupt id
- PULP_SECURE, 0, 1 enables user-mode/secure enable qualification

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- setback_i  in  1  synchronous clear of FSM, latched id/sec and all pending bits
- irq_i  in  NUM_IRQ  interrupt lines
- irq_sec_i  in  NUM_IRQ  per-line secure bit
- irq_mask_i  in  NUM_IRQ  per-line enable (1 = enabled)
- irq_edge_i  in  NUM_IRQ  per-line mode (1 = rising-edge, 0 = level)
- m_IE_i  in  1  M-mode global interrupt enable
- u_IE_i  in  1  U-mode global interrupt enable
- current_priv_lvl_i  in  PrivLvl_t  current privilege level
- irq_req_ctrl_o  out  1  request to core controller
- irq_sec_ctrl_o  out  1  secure bit of the latched request
- irq_id_ctrl_o  out  ID_W  id of the latched request
- ctrl_ack_i  in  1  controller accepted the request
- ctrl_kill_i  in  1  controller dropped the request
- irq_ack_o  out  1  one-cycle acknowledge to the source
- irq_ack_id_o  out  ID_W  id being acknowledged

Behaviour:
- Reset: FSM=IDLE; id_q=0; sec_q=0; pend_q=0; irq_prev_q=0. Resulting outputs: irq_req_ctrl_o=0, irq_sec_ctrl_o=0, irq_id_ctrl_o=0, irq_ack_o=0, irq_ack_id_o=0.
- irq_prev_q samples irq_i every cycle, including during setback.
- Edge lines: the pend_q bit sets on irq_i & ~irq_prev_q. The bit clears when the FSM enters IRQ_DONE with id_q equal to that line. If set and clear occur in the same cycle, set wins.
- pend_q bits of level lines are held at 0.
- Effective pending vector eff = (irq_edge_i ? pend_q : irq_i) & irq_mask_i.
- Selection: highest set index of eff wins (fixed priority, NUM_IRQ-1 highest). Combinational.
- Global enable:
  - PULP_SECURE=1: ((u_IE_i | sel_sec) & priv==U) | (m_IE_i & priv==M), where sel_sec = irq_sec_i[sel].
  - PULP_SECURE=0: m_IE_i.
- FSM IDLE: if any eff bit is set and enable=1, latch id_q=sel and sec_q=irq_sec_i[sel], then go to IRQ_PENDING.
- FSM IRQ_PENDING:
  - ctrl_ack_i → IRQ_DONE (ack has priority over a simultaneous kill).
  - ctrl_kill_i alone → IDLE; pending bit is retained.
  - Otherwise stay. id_q and sec_q are frozen while in this state, even if a higher-priority line arrives.
- FSM IRQ_DONE: irq_ack_o=1 and irq_ack_id_o=id_q for exactly this cycle; sec_q←0; next state IDLE.
- Outputs: irq_req_ctrl_o = (state==IRQ_PENDING); irq_sec_ctrl_o = sec_q; irq_id_ctrl_o = id_q.
- Latency, level line: asserted in cycle n → irq_req_ctrl_o high in n+1.
- Latency, edge line: rising edge in cycle n → pend_q set in n+1 → irq_req_ctrl_o high in n+2.
- Minimum spacing between two taken interrupts: 3 cycles (PENDING, DONE, IDLE).
- setback_i takes priority over all FSM and pending updates. A setback mid-request drops irq_req_ctrl_o the next cycle and produces no irq_ack_o.
- Masking a line while it is PENDING does not withdraw the request.
- Masking an edge line keeps its pend_q bit, so the request fires once the line is unmasked.
- Illegal FSM encoding → IDLE.

Decomposition:
- riscv_defines package (existing): PrivLvl_t, PRIV_LVL_U/M.
- New package entry: int_ctrl_state_e {IDLE, IRQ_PENDING, IRQ_DONE}.
- Sub-module riscv_irq_prio_sel(NUM_IRQ, ID_W): combinational highest-index priority encoder with outputs valid_o and id_o. Instantiated once.

Test Plan:
- Level, line 5, mask all, m_IE=1, PULP_SECURE=0: irq_i=0x20 at cycle 0 → req=1, id=5 at cycle 1; ack at cycle 3 → irq_ack_o=1, ack_id=5 at cycle 4; IDLE at cycle 5.
- Priority: irq_i=0x0000_8104 (levels) → id=15. A later raise of line 20 while PENDING leaves id=15. After ack and DONE, next request has id=20.
- Edge line 3:
  - 1-cycle pulse with mask=0 → no req, pend_q[3]=1.
  - Unmask → req id=3.
  - After ack, pend_q[3]=0 and no re-request.
  - New pulse in the DONE cycle → pend_q[3] stays 1, re-request follows.
- Kill vs ack: kill alone → IDLE, no irq_ack_o, and the same id is re-requested 2 cycles later. Ack and kill together → DONE with irq_ack_o=1.
- PULP_SECURE=1, priv=U, u_IE=0:
  - Line 7 with sec=0 → no req.
  - Line 7 with sec=1 → req with irq_sec_ctrl_o=1.
  - priv=M, m_IE=0 → no req.
- setback_i during PENDING with pending edge bits → next cycle req=0, id=0, sec=0, pend_q=0, no irq_ack_o. Async rst_n mid-DONE → all outputs 0 immediately.
